// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register-file write port plus a zeroing clear sequencer
module regfile_write_arbiter #(
    parameter int ADDR_W           = 5,
    parameter int DATA_W           = 32,
    parameter int NUM_REGS         = 32,
    parameter bit ZERO_REG_PROTECT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              rf_reg_write,
    output logic [ADDR_W-1:0] rf_write_add,
    output logic [DATA_W-1:0] rf_write_data
);
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_REGS - 1);
    state_t            state;
    logic [ADDR_W:0]   count;
    logic              last_grant;
    logic              open;
    logic              grant0;
    logic              grant1;
    logic              issue;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    always_comb begin
        open       = state == IDLE && !clear_start;
        grant0     = open && req0_valid && (!req1_valid || last_grant);
        grant1     = open && req1_valid && (!req0_valid || !last_grant);
        grant_addr = grant1 ? req1_addr : req0_addr;
        grant_data = grant1 ? req1_data : req0_data;
        issue      = (grant0 || grant1) && !(ZERO_REG_PROTECT && grant_addr == '0);
    end
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            last_grant    <= 1'b1;
            clear_busy    <= 1'b0;
            rf_reg_write  <= 1'b0;
            rf_write_add  <= '0;
            rf_write_data <= '0;
        end else if (state == CLEAR) begin
            rf_reg_write  <= 1'b1;
            rf_write_add  <= count[ADDR_W-1:0];
            rf_write_data <= '0;
            count         <= count + 1'b1;
            if (count == LAST) begin
                state      <= IDLE;
                clear_busy <= 1'b0;
            end
        end else begin
            rf_reg_write <= issue;
            if (issue) begin
                rf_write_add  <= grant_addr;
                rf_write_data <= grant_data;
            end
            if (grant0 || grant1)
                last_grant <= grant1;
            if (clear_start) begin
                state      <= CLEAR;
                count      <= '0;
                clear_busy <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed steps with a reference model feeding an expected-write scoreboard
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, clear_start = 1'b0;
    logic [4:0]  req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, clear_busy, rf_reg_write;
    logic [4:0]  rf_write_add;
    logic [31:0] rf_write_data;
    int          checks = 0, errors = 0;
    logic [36:0] sb[$];
    bit          m_busy = 1'b0, m_last = 1'b1, last_g0, last_g1;
    int          m_cnt = 0;

    regfile_write_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .rf_reg_write(rf_reg_write), .rf_write_add(rf_write_add), .rf_write_data(rf_write_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven just after a rising edge; readies are judged mid-cycle, rf_* just after the next edge.
    task automatic cycle();
        bit g0, g1, iss;
        logic [4:0]  a;
        logic [31:0] d;
        logic [36:0] e;
        #1;
        g0 = 0; g1 = 0; iss = 0; a = '0; d = '0;
        if (m_busy) begin
            iss = 1; a = m_cnt[4:0]; d = '0;
            m_cnt++;
            if (m_cnt == 32) m_busy = 0;
        end else if (clear_start) begin
            m_busy = 1; m_cnt = 0;
        end else begin
            g0 = req0_valid && (!req1_valid || m_last);
            g1 = req1_valid && !g0;
            if (g0) m_last = 0;
            if (g1) m_last = 1;
            a = g1 ? req1_addr : req0_addr;
            d = g1 ? req1_data : req0_data;
            iss = (g0 || g1) && a != 0;
        end
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        last_g0 = g0; last_g1 = g1;
        if (iss) sb.push_back({a, d});
        @(posedge clk); #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rf_reg_write", rf_reg_write, 1);
            chk("rf_write_add", rf_write_add, e[36:32]);
            chk("rf_write_data", rf_write_data, e[31:0]);
        end else
            chk("rf_reg_write_idle", rf_reg_write, 0);
        chk("clear_busy", clear_busy, m_busy);
    endtask

    initial begin
        int n;
        logic [3:0] seq;
        #1;
        chk("rst_reg_write", rf_reg_write, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_add", rf_write_add, 0);
        chk("rst_data", rf_write_data, 0);
        @(posedge clk); #1;
        reset = 0;
        // single write from requester 0
        req0_valid = 1; req0_addr = 3; req0_data = 32'hA5;
        cycle();
        chk("t1_grant", last_g0, 1);
        chk("t1_add", rf_write_add, 3);
        chk("t1_data", rf_write_data, 32'hA5);
        req0_valid = 0;
        cycle();
        chk("t1_drop", rf_reg_write, 0);
        // requester 1 to register 0 is consumed but not issued
        req1_valid = 1; req1_addr = 0; req1_data = 32'hFFFF_FF5A;
        cycle();
        chk("t3_ready", last_g1, 1);
        chk("t3_no_write", rf_reg_write, 0);
        req1_valid = 0;
        cycle();
        // contention alternates starting with requester 0
        req0_valid = 1; req0_addr = 1; req0_data = 32'h11;
        req1_valid = 1; req1_addr = 2; req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq[3-i] = last_g1;
            chk("t2_add_seq", rf_write_add, (i % 2 == 0) ? 1 : 2);
        end
        chk("t2_order", seq, 4'b0101);
        req1_valid = 0;
        // clear with requester 0 waiting
        req0_addr = 7; req0_data = 32'h77;
        clear_start = 1;
        cycle();
        clear_start = 0;
        n = 1;
        do begin
            cycle();
            if (!last_g0) n++;
        end while (!last_g0 && n < 60);
        chk("t4_ready_low_cycles", n, 33);
        req0_valid = 0;
        cycle();
        // a second clear_start mid-sequence is ignored
        clear_start = 1;
        cycle();
        clear_start = 0;
        n = 0;
        while (m_cnt < 11 && n < 60) begin cycle(); n++; end
        chk("t5_at_write10", rf_write_add, 10);
        clear_start = 1;
        cycle();
        clear_start = 0;
        n = 0;
        while (m_busy && n < 60) begin cycle(); n++; end
        chk("t5_last_add", rf_write_add, 31);
        chk("t5_len", n, 20);
        cycle();
        chk("t5_done", rf_reg_write, 0);
        // asynchronous reset aborts a clear in progress
        clear_start = 1;
        cycle();
        clear_start = 0;
        n = 0;
        while (m_cnt < 16 && n < 60) begin cycle(); n++; end
        chk("t6_at_write15", rf_write_add, 15);
        reset = 1;
        #1;
        chk("t6_busy_async", clear_busy, 0);
        chk("t6_write_async", rf_reg_write, 0);
        sb.delete();
        m_busy = 0; m_cnt = 0; m_last = 1;
        @(posedge clk); #1;
        reset = 0;
        req0_valid = 1; req0_addr = 4; req0_data = 32'h44;
        req1_valid = 1; req1_addr = 5; req1_data = 32'h55;
        cycle();
        chk("t6_req0_first", last_g0, 1);
        cycle();
        chk("t6_req1_next", last_g1, 1);
        req0_valid = 0; req1_valid = 0;
        cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
